// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver; LSB-first word with a one-clock rx_done strobe.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data and a parity_error output.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_done,
  output logic                 frame_error
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_error
`endif
);

  localparam int S_W = $clog2(OVERSAMPLE);
  localparam int N_W = $clog2(DATA_BITS);
  localparam logic [S_W-1:0] S_MID  = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state, state_next;
  logic [S_W-1:0]       s, s_next;
  logic [N_W-1:0]       n, n_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic                 rx_meta, rx_s;
  logic                 finish;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
      shift <= '0;
    end else begin
      state <= state_next;
      s     <= s_next;
      n     <= n_next;
      shift <= shift_next;
    end
  end

  always_comb begin
    state_next = state;
    s_next     = s;
    n_next     = n;
    shift_next = shift;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          s_next     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s == S_MID) begin
            s_next     = '0;
            n_next     = '0;
            state_next = rx_s ? IDLE : DATA;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s == S_LAST) begin
            s_next     = '0;
            shift_next = {rx_s, shift[DATA_BITS-1:1]};
            if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end else begin
              n_next = n + 1'b1;
            end
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (s == S_LAST) begin
            s_next     = '0;
            state_next = STOP;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (s == S_LAST) begin
            state_next = IDLE;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    finish = (state == STOP) && tick && (s == S_LAST);
  end

`ifdef UART_RX_PARITY_EN
  logic perr_q;

  // Parity result is held until the stop-bit sample publishes the whole frame.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      perr_q <= 1'b0;
    end else if ((state == PARITY) && tick && (s == S_LAST)) begin
      perr_q <= rx_s ^ (^shift);
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      data_out    <= '0;
      rx_done     <= 1'b0;
      frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error <= 1'b0;
`endif
    end else begin
      rx_done <= finish;
      if (finish) begin
        data_out    <= shift;
        frame_error <= ~rx_s;
`ifdef UART_RX_PARITY_EN
        parity_error <= perr_q;
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx; frames are modelled as bit sequences.
// Build with UART_RX_PARITY_EN defined to exercise the parity variant as well.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  // A short tick period keeps the run small; the receiver only counts ticks.
  localparam int TICK_DIV   = 7;
  localparam int BIT_CLKS   = OVERSAMPLE * TICK_DIV;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = DATA_BITS + 3;
`else
  localparam int FRAME_BITS = DATA_BITS + 2;
`endif
  localparam int W = DATA_BITS + 2;

  logic                 clock   = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 tick    = 1'b0;
  logic                 rx      = 1'b1;
  logic [DATA_BITS-1:0] data_out;
  logic                 rx_done;
  logic                 frame_error;
`ifdef UART_RX_PARITY_EN
  logic                 parity_error;
  logic                 par_flip = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int tick_cnt = 0;

  // Words are {perr, ferr, data}; perr is always 0 without the parity feature.
  logic [W-1:0] got_q[$];
  logic [W-1:0] exp_q[$];

  uart_rx #(.DATA_BITS(DATA_BITS), .OVERSAMPLE(OVERSAMPLE)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .tick        (tick),
    .rx          (rx),
    .data_out    (data_out),
    .rx_done     (rx_done),
    .frame_error (frame_error)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_error(parity_error)
`endif
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    tick_cnt = (tick_cnt == TICK_DIV - 1) ? 0 : tick_cnt + 1;
    tick = (tick_cnt == 0);
  end

  // Every clock rx_done is high is recorded, so a stretched pulse shows up as an extra word.
  always @(negedge clock) begin
    if (rx_done === 1'b1) begin
`ifdef UART_RX_PARITY_EN
      got_q.push_back({parity_error, frame_error, data_out});
`else
      got_q.push_back({1'b0, frame_error, data_out});
`endif
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic hold_line(input logic v, input int clks);
    rx = v;
    repeat (clks) @(negedge clock);
  endtask

  // Drives one frame and records what a correct receiver must report for it.
  // A low stop bit is released after 3/4 of a bit so the re-armed start search sees idle.
  task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic stop);
    logic perr_exp;
    perr_exp = 1'b0;
    hold_line(1'b0, BIT_CLKS);
    for (int i = 0; i < DATA_BITS; i++) hold_line(d[i], BIT_CLKS);
`ifdef UART_RX_PARITY_EN
    hold_line((^d) ^ par_flip, BIT_CLKS);
    perr_exp = ((^d) ^ par_flip) ^ (^d);
`endif
    if (stop) begin
      hold_line(1'b1, BIT_CLKS);
    end else begin
      hold_line(1'b0, BIT_CLKS * 3 / 4);
      hold_line(1'b1, BIT_CLKS - BIT_CLKS * 3 / 4);
    end
    exp_q.push_back({perr_exp, ~stop, d});
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    rx = 1'b1;
    repeat (4) @(negedge clock);
    n_checks++;
    if (data_out !== '0) $display("[TB] FAIL reset_data: got %h want 00", data_out);
    else n_pass++;
    n_checks++;
    if (rx_done !== 1'b0) $display("[TB] FAIL reset_done: got %b want 0", rx_done);
    else n_pass++;
    n_checks++;
    if (frame_error !== 1'b0) $display("[TB] FAIL reset_ferr: got %b want 0", frame_error);
    else n_pass++;
`ifdef UART_RX_PARITY_EN
    n_checks++;
    if (parity_error !== 1'b0) $display("[TB] FAIL reset_perr: got %b want 0", parity_error);
    else n_pass++;
`endif
    reset_n = 1'b1;
    hold_line(1'b1, 2 * BIT_CLKS);
  endtask

  task automatic test_single_frame;
    send_frame(8'h55, 1'b1);
    hold_line(1'b1, BIT_CLKS);
    n_checks++;
    if (got_q.size() !== 1) $display("[TB] FAIL single_count: got %0d pulses want 1", got_q.size());
    else n_pass++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [W-1:0] g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (g !== e) $display("[TB] FAIL single_word: got %h want %h", g, e);
      else n_pass++;
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_false_start;
    hold_line(1'b0, 4 * TICK_DIV);
    hold_line(1'b1, FRAME_BITS * BIT_CLKS);
    n_checks++;
    if (got_q.size() !== 0) $display("[TB] FAIL glitch_count: got %0d pulses want 0", got_q.size());
    else n_pass++;
    n_checks++;
    if (data_out !== 8'h55) $display("[TB] FAIL glitch_hold: got %h want 55", data_out);
    else n_pass++;
    got_q.delete();
  endtask

  task automatic test_frame_error;
    send_frame(8'hA5, 1'b0);
    hold_line(1'b1, BIT_CLKS);
    send_frame(8'h3C, 1'b1);
    hold_line(1'b1, BIT_CLKS);
    n_checks++;
    if (got_q.size() !== 2) $display("[TB] FAIL ferr_count: got %0d pulses want 2", got_q.size());
    else n_pass++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [W-1:0] g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (g !== e) $display("[TB] FAIL ferr_word: got %h want %h", g, e);
      else n_pass++;
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back;
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    send_frame(8'hFF, 1'b1);
    hold_line(1'b1, BIT_CLKS);
    n_checks++;
    if (got_q.size() !== 3) $display("[TB] FAIL b2b_count: got %0d pulses want 3", got_q.size());
    else n_pass++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [W-1:0] g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (g !== e) $display("[TB] FAIL b2b_word: got %h want %h", g, e);
      else n_pass++;
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // Upper data bits are kept high so the line stays idle after the reset drops the frame.
  task automatic test_reset_mid_frame;
    logic [DATA_BITS-1:0] d;
    d = {5'b11111, 3'($urandom_range(0, 7))};
    hold_line(1'b0, BIT_CLKS);
    for (int i = 0; i < 3; i++) hold_line(d[i], BIT_CLKS);
    hold_line(d[3], BIT_CLKS / 2);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    hold_line(d[3], BIT_CLKS - BIT_CLKS / 2 - 1);
    for (int i = 4; i < DATA_BITS; i++) hold_line(d[i], BIT_CLKS);
`ifdef UART_RX_PARITY_EN
    hold_line(1'b1, BIT_CLKS);
`endif
    hold_line(1'b1, 2 * BIT_CLKS);
    n_checks++;
    if (got_q.size() !== 0) $display("[TB] FAIL rstmid_count: got %0d pulses want 0", got_q.size());
    else n_pass++;
    n_checks++;
    if (data_out !== '0) $display("[TB] FAIL rstmid_data: got %h want 00", data_out);
    else n_pass++;
    n_checks++;
    if (frame_error !== 1'b0) $display("[TB] FAIL rstmid_ferr: got %b want 0", frame_error);
    else n_pass++;
    got_q.delete();
    send_frame(8'h81, 1'b1);
    hold_line(1'b1, BIT_CLKS);
    n_checks++;
    if (got_q.size() !== 1) $display("[TB] FAIL rstmid_next_count: got %0d pulses want 1", got_q.size());
    else n_pass++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [W-1:0] g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (g !== e) $display("[TB] FAIL rstmid_next_word: got %h want %h", g, e);
      else n_pass++;
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // A break looks like an all-zero frame with a low stop bit; released before the next start sample.
  task automatic test_break;
    hold_line(1'b0, (FRAME_BITS - 1) * BIT_CLKS + BIT_CLKS * 3 / 4);
    hold_line(1'b1, 2 * BIT_CLKS);
    exp_q.push_back({1'b0, 1'b1, {DATA_BITS{1'b0}}});
    n_checks++;
    if (got_q.size() !== 1) $display("[TB] FAIL break_count: got %0d pulses want 1", got_q.size());
    else n_pass++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [W-1:0] g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (g !== e) $display("[TB] FAIL break_word: got %h want %h", g, e);
      else n_pass++;
    end
    got_q.delete();
    exp_q.delete();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    par_flip = 1'b0;
    send_frame(8'h03, 1'b1);
    par_flip = 1'b1;
    send_frame(8'h03, 1'b1);
    par_flip = 1'b0;
    hold_line(1'b1, BIT_CLKS);
    n_checks++;
    if (got_q.size() !== 2) $display("[TB] FAIL parity_count: got %0d pulses want 2", got_q.size());
    else n_pass++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [W-1:0] g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (g !== e) $display("[TB] FAIL parity_word: got %h want %h", g, e);
      else n_pass++;
    end
    got_q.delete();
    exp_q.delete();
  endtask
`endif

  task automatic test_random;
    logic [DATA_BITS-1:0] d;
    logic                 stop;
    for (int k = 0; k < 8; k++) begin
      d    = DATA_BITS'($urandom);
      stop = ($urandom_range(0, 3) != 0);
`ifdef UART_RX_PARITY_EN
      par_flip = 1'($urandom_range(0, 1));
`endif
      send_frame(d, stop);
      hold_line(1'b1, stop ? $urandom_range(1, BIT_CLKS / 2) : BIT_CLKS);
    end
    hold_line(1'b1, BIT_CLKS);
    n_checks++;
    if (got_q.size() !== 8) $display("[TB] FAIL random_count: got %0d pulses want 8", got_q.size());
    else n_pass++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [W-1:0] g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (g !== e) $display("[TB] FAIL random_word: got %h want %h", g, e);
      else n_pass++;
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_single_frame();
    test_false_start();
    test_frame_error();
    test_back_to_back();
    test_reset_mid_frame();
    test_break();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; sits directly downstream of the baud-rate generator and consumes its 16x-oversampling `tick` (one-clock pulse every 163 clocks).
- Synchronises the serial `rx` line, detects the start bit, samples each bit at its midpoint and assembles an LSB-first data word.
- Presents the word with a one-clock `rx_done` strobe and a `frame_error` flag to the downstream interface/FIFO logic.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..8).
- OVERSAMPLE, 16, ticks per bit period. Must be even and match the baud-rate generator.

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset_n  input  1  synchronous reset, active low.
- tick  input  1  oversampling strobe from the baud-rate generator; one clock wide.
- rx  input  1  asynchronous serial line; idle high.
- data_out  output  DATA_BITS  last received word, LSB = first bit on the line.
- rx_done  output  1  one-clock pulse; data_out/frame_error valid.
- frame_error  output  1  stop bit sampled low on the last frame.

Behaviour:
- Reset (reset_n=0 at posedge):
  - state=IDLE; sample counter s=0; bit counter n=0; shift register=0.
  - data_out=0, rx_done=0, frame_error=0.
  - Synchroniser flops = 1.
  - Reset mid-frame aborts the frame with no rx_done.
- Synchroniser:
  - rx passes through 2 flops (rx_s); all decisions use rx_s only.
  - Adds 2 clocks of latency, which is negligible against the 163-clock tick.
- State machine:
  - IDLE: when rx_s==0, go to START and set s=0. This check is evaluated every clock, not only on tick.
  - START, on tick:
    - If s==OVERSAMPLE/2-1: if rx_s==0, go to DATA with s=0, n=0. If rx_s==1 (glitch/false start), go to IDLE.
    - Otherwise s=s+1.
  - DATA, on tick:
    - If s==OVERSAMPLE-1: s=0; shift = {rx_s, shift[DATA_BITS-1:1]}. If n==DATA_BITS-1, go to STOP (or PARITY, see below); otherwise n=n+1.
    - Otherwise s=s+1.
  - STOP, on tick:
    - If s==OVERSAMPLE-1: data_out=shift; frame_error=~rx_s; rx_done=1 for exactly one clock; go to IDLE.
    - Otherwise s=s+1.
- Ticks are ignored in IDLE. No state advances without a tick, except the IDLE→START transition.
- rx_done is registered and is asserted in the clock after the tick that samples mid-stop.
- data_out and frame_error hold until the next rx_done. data_out is updated even when frame_error=1.
- Back-to-back frames: a start bit immediately after the stop-bit sample is detected normally. The half stop bit remaining after the mid-sample is absorbed because IDLE waits for rx_s==0.
- A line held low (break) produces frame_error=1 with data_out=0, then re-enters START on the next clock. It repeats every frame time while the line stays low.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Extra state PARITY between DATA and STOP, lasting one bit period.
  - On its mid-sample (s==OVERSAMPLE-1), perr = rx_s ^ (^shift), checking even parity.
  - Extra output port parity_error (1 bit, reset 0), updated together with data_out at the rx_done pulse.
  - A frame is 1+DATA_BITS+1+1 bits long.
- Undefined: no PARITY state and no parity_error port; a frame is 1+DATA_BITS+1 bits long.

Test Plan:
- Tick every 163 clocks; frame 0x55 (LSB first), stop=1 → exactly one rx_done pulse; data_out=0x55, frame_error=0. rx_done occurs about 9.5 bit periods after the falling edge (≈24,800 clocks).
- rx low for 4 ticks, then high → returns to IDLE with no rx_done; data_out keeps its previous value.
- Frame 0xA5 with stop bit driven 0 → rx_done pulses, data_out=0xA5, frame_error=1. A following clean 0x3C frame gives frame_error=0.
- Back-to-back frames 0xA5, 0x3C, 0xFF with no idle gap → three rx_done pulses carrying those values in order.
- reset_n=0 for one clock during bit 3 of a frame → no rx_done for that frame; outputs are 0. The next full frame 0x81 is received correctly.
- With UART_RX_PARITY_EN: 0x03 with parity bit 0 → parity_error=0. 0x03 with parity bit 1 → parity_error=1, data_out=0x03.
